instr_fetch_unit: RTL and testbench

Fetch-side responder for the program counter: accepts one word-indexed instruction address per handshake, issues it to instruction memory over a request/grant/response interface, and buffers returned instructions with their addresses in a small FIFO toward decode. Sits between the PC register and the decode stage of the RISC-V core. It decouples memory wait states from decode and discards in-flight and buffered fetches on a control-flow flush.

---
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: accepts word-indexed PCs, issues one outstanding
// instruction-memory read at a time (req/gnt/rvalid), and buffers returned
// words with their PCs in a small FIFO toward decode. Flush discards both
// buffered entries and the in-flight response.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode in the cycle it arrives when the FIFO is empty.
module instr_fetch_unit #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    output logic            pc_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            flush,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pend_pc;
    logic              r_drop;

    logic [XLEN-1:0]   r_mem_data [DEPTH];
    logic [XLEN-1:0]   r_mem_pc   [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_rsp_ok;
    logic              w_fifo_valid;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;

    // Handshake and response qualification; a response is usable only when
    // it belongs to a fetch that was not flushed and no flush is happening now.
    assign pc_ready     = (r_state == IDLE) && !flush && (r_count < DEPTH_C);
    assign w_accept     = pc_valid && pc_ready;
    assign w_rsp_ok     = (r_state == WAIT) && imem_rvalid && !r_drop && !flush;
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = w_fifo_valid && inst_ready;

`ifdef FETCH_BYPASS_EN
    assign w_bypass   = w_rsp_ok && !w_fifo_valid;
    assign w_push     = w_rsp_ok && !(w_bypass && inst_ready);
    assign inst_valid = w_fifo_valid || w_bypass;
    assign inst_data  = w_bypass ? imem_rdata : r_mem_data[r_rptr];
    assign inst_pc    = w_bypass ? r_pend_pc  : r_mem_pc[r_rptr];
`else
    assign w_bypass   = 1'b0;
    assign w_push     = w_rsp_ok && !w_bypass;
    assign inst_valid = w_fifo_valid;
    assign inst_data  = r_mem_data[r_rptr];
    assign inst_pc    = r_mem_pc[r_rptr];
`endif

    // Fetch FSM: one outstanding request, request held until granted even
    // across a flush; the drop flag marks the in-flight response as stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pend_pc <= '0;
            r_drop    <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        imem_addr <= pc_in;
                        r_pend_pc <= pc_in;
                        imem_req  <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= IDLE;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_drop   <= 1'b0;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Instruction FIFO: flush empties it outright and overrides any push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= imem_rdata;
                r_mem_pc[r_wptr]   <= r_pend_pc;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=2, XLEN=32).
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit #(.DEPTH(2), .XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch with zero-wait grant and response one cycle after grant.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
        pc_in    = pc;
        pc_valid = 1'b1;
        #1;
        chk("fetch_pc_ready", {31'b0, pc_ready}, 32'd1);
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, pc);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        pc_in       = '0;
        pc_valid    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        flush       = 1'b0;
        inst_ready  = 1'b0;
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_data", inst_data, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic fetch of pc 0x0, zero-wait grant
        pc_in    = 32'h0;
        pc_valid = 1'b1;
        #1;
        chk("a_pc_ready", {31'b0, pc_ready}, 32'd1);
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("a_req", {31'b0, imem_req}, 32'd1);
        chk("a_addr", imem_addr, 32'h0);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h00500093;
        #1;
        chk("a_req_drop", {31'b0, imem_req}, 32'd0);
`ifdef FETCH_BYPASS_EN
        chk("a_bypass_valid", {31'b0, inst_valid}, 32'd1);
        chk("a_bypass_data", inst_data, 32'h00500093);
`else
        chk("a_no_bypass", {31'b0, inst_valid}, 32'd0);
`endif
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("a_valid", {31'b0, inst_valid}, 32'd1);
        chk("a_inst_pc", inst_pc, 32'h0);
        chk("a_inst_data", inst_data, 32'h00500093);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        chk("a_popped", {31'b0, inst_valid}, 32'd0);

        // FIFO fills at DEPTH=2, third PC held until a pop
        do_fetch(32'h1, 32'hA1);
        do_fetch(32'h2, 32'hA2);
        chk("b_full_ready", {31'b0, pc_ready}, 32'd0);
        chk("b_head_pc1", inst_pc, 32'h1);
        chk("b_head_data1", inst_data, 32'hA1);
        pc_in    = 32'h3;
        pc_valid = 1'b1;
        tick();
        tick();
        chk("b_held_req", {31'b0, imem_req}, 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        #1;
        chk("b_ready_after_pop", {31'b0, pc_ready}, 32'd1);
        chk("b_head_pc2", inst_pc, 32'h2);
        chk("b_head_data2", inst_data, 32'hA2);
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("b_req3", {31'b0, imem_req}, 32'd1);
        chk("b_addr3", imem_addr, 32'h3);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA3;
        tick();
        imem_rvalid = 1'b0;
        inst_ready  = 1'b1;
        #1;
        chk("b_order2", inst_pc, 32'h2);
        tick();
        chk("b_order3_pc", inst_pc, 32'h3);
        chk("b_order3_data", inst_data, 32'hA3);
        tick();
        inst_ready = 1'b0;
        #1;
        chk("b_empty", {31'b0, inst_valid}, 32'd0);

        // Flush in WAIT for pc 0x7: response discarded
        pc_in    = 32'h7;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        #1;
        chk("c_flush_ready", {31'b0, pc_ready}, 32'd0);
        tick();
        flush       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h77;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("c_dropped", {31'b0, inst_valid}, 32'd0);
        chk("c_idle_ready", {31'b0, pc_ready}, 32'd1);

        // Flush coincident with pc_valid in IDLE
        pc_in    = 32'h9;
        pc_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("d_flush_block", {31'b0, pc_ready}, 32'd0);
        tick();
        chk("d_no_req", {31'b0, imem_req}, 32'd0);
        flush = 1'b0;
        #1;
        chk("d_ready_again", {31'b0, pc_ready}, 32'd1);
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("d_req", {31'b0, imem_req}, 32'd1);
        chk("d_addr", imem_addr, 32'h9);
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h99;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("d_inst_pc", inst_pc, 32'h9);
        chk("d_inst_data", inst_data, 32'h99);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // Grant delayed 3 cycles, flush during REQ drops the data
        pc_in    = 32'h20;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        pc_in    = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("e_req_hold", {31'b0, imem_req}, 32'd1);
            chk("e_addr_hold", imem_addr, 32'h20);
            if (i == 1) flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        imem_gnt = 1'b1;
        #1;
        chk("e_req_4th", {31'b0, imem_req}, 32'd1);
        chk("e_addr_4th", imem_addr, 32'h20);
        tick();
        imem_gnt = 1'b0;
        #1;
        chk("e_req_low", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("e_dropped", {31'b0, inst_valid}, 32'd0);
        chk("e_ready", {31'b0, pc_ready}, 32'd1);

        // Flush empties a non-empty FIFO
        do_fetch(32'h30, 32'h3333);
        chk("f_valid", {31'b0, inst_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("f_flushed", {31'b0, inst_valid}, 32'd0);

        // Reset mid-WAIT with pc 0x5 outstanding and an entry buffered
        do_fetch(32'h4, 32'h44);
        pc_in    = 32'h5;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset    = 1'b0;
        #1;
        chk("g_req", {31'b0, imem_req}, 32'd0);
        chk("g_addr", imem_addr, 32'h0);
        chk("g_valid", {31'b0, inst_valid}, 32'd0);
        chk("g_data", inst_data, 32'h0);
        chk("g_pc", inst_pc, 32'h0);
        tick();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        #1;
        chk("g_late_rvalid", {31'b0, inst_valid}, 32'd0);
        tick();
        chk("g_still_empty", {31'b0, inst_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
